// File: rtl/sbox_lane_arbiter_pkg.sv
// Shared types and the FIPS-197 forward S-box table for the shared lane.
// Imported by the lane and the arbiter.
package sbox_lane_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_KS_RUN,
        S_ST_RUN,
        S_RESP
    } fsm_t;

    typedef enum logic {
        GRANT_ST,
        GRANT_KS
    } grant_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/sbox_lane_arbiter_sbox_word.sv
// One 32-bit S-box lane: four independent byte lookups, purely combinational.
// Bytes never cross positions.
module sbox_word
    import sbox_lane_arbiter_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign word_o[8*i +: 8] = SBOX[word_i[8*i +: 8]];
    end

endmodule

// File: rtl/sbox_lane_arbiter.sv
// Arbitrates one shared S-box lane between the state path (4 beats)
// and the key-schedule path (1 beat).
module sbox_lane_arbiter
    import sbox_lane_arbiter_pkg::*;
#(
    parameter bit KS_PRIORITY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_req_valid,
    output logic         st_req_ready,
    input  logic [127:0] st_req_data,
    output logic         st_rsp_valid,
    output logic [127:0] st_rsp_data,
    input  logic         ks_req_valid,
    output logic         ks_req_ready,
    input  logic [31:0]  ks_req_data,
    output logic         ks_rsp_valid,
    output logic [31:0]  ks_rsp_data,
    output logic         busy
);

    fsm_t         state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    grant_t       last_q, last_d;
    logic [127:0] in_q, in_d;
    logic [127:0] st_rsp_q, st_rsp_d;
    logic [31:0]  ks_rsp_q, ks_rsp_d;
    logic [31:0]  lane_in, lane_out;
    logic         pick_ks;

    // On a tie without priority, KS wins only if ST had the last grant.
    assign pick_ks = ks_req_valid
                   & (~st_req_valid | KS_PRIORITY | (last_q == GRANT_ST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            S_IDLE: begin
                beat_d = 2'd0;
                if (ks_req_ready) begin
                    state_d = S_KS_RUN;
                end else if (st_req_ready) begin
                    state_d = S_ST_RUN;
                end
            end
            S_KS_RUN: state_d = S_RESP;
            S_ST_RUN: begin
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ks_req_ready = 1'b0;
        st_req_ready = 1'b0;
        ks_rsp_valid = 1'b0;
        st_rsp_valid = 1'b0;
        busy         = (state_q != S_IDLE);
        if (state_q == S_IDLE) begin
            ks_req_ready = pick_ks;
            st_req_ready = st_req_valid & ~pick_ks;
        end
        if (state_q == S_RESP) begin
            ks_rsp_valid = (last_q == GRANT_KS);
            st_rsp_valid = (last_q == GRANT_ST);
        end
    end

    assign lane_in = (state_q == S_KS_RUN) ? in_q[31:0]
                                           : in_q[{beat_q, 5'd0} +: 32];

    sbox_word u_lane (
        .word_i (lane_in),
        .word_o (lane_out)
    );

    always_comb begin
        in_d     = in_q;
        last_d   = last_q;
        st_rsp_d = st_rsp_q;
        ks_rsp_d = ks_rsp_q;
        if (ks_req_ready) begin
            in_d[31:0] = ks_req_data;
            last_d     = GRANT_KS;
        end else if (st_req_ready) begin
            in_d   = st_req_data;
            last_d = GRANT_ST;
        end
        if (state_q == S_KS_RUN) begin
            ks_rsp_d = lane_out;
        end
        if (state_q == S_ST_RUN) begin
            st_rsp_d[{beat_q, 5'd0} +: 32] = lane_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= GRANT_ST;
            in_q     <= '0;
            st_rsp_q <= '0;
            ks_rsp_q <= '0;
        end else begin
            last_q   <= last_d;
            in_q     <= in_d;
            st_rsp_q <= st_rsp_d;
            ks_rsp_q <= ks_rsp_d;
        end
    end

    assign st_rsp_data = st_rsp_q;
    assign ks_rsp_data = ks_rsp_q;

endmodule

// File: tb/tb_sbox_lane_arbiter.sv
// Directed bench for sbox_lane_arbiter: latency, data, arbitration, reset.
// A second instance runs with round-robin arbitration.
module tb_sbox_lane_arbiter;

    logic         clk;
    logic         rst_n;
    logic         st_req_valid, st_req_ready, st_rsp_valid;
    logic [127:0] st_req_data, st_rsp_data;
    logic         ks_req_valid, ks_req_ready, ks_rsp_valid;
    logic [31:0]  ks_req_data, ks_rsp_data;
    logic         busy;

    logic         rr_st_valid, rr_st_ready, rr_st_rsp_valid;
    logic [127:0] rr_st_data, rr_st_rsp_data;
    logic         rr_ks_valid, rr_ks_ready, rr_ks_rsp_valid;
    logic [31:0]  rr_ks_data, rr_ks_rsp_data;
    logic         rr_busy;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] ST_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] ST_OUT = 128'h638293c3_1bfc33f5_c4eeacea_4bc12816;

    sbox_lane_arbiter #(.KS_PRIORITY(1'b1)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_req_valid (st_req_valid),
        .st_req_ready (st_req_ready),
        .st_req_data  (st_req_data),
        .st_rsp_valid (st_rsp_valid),
        .st_rsp_data  (st_rsp_data),
        .ks_req_valid (ks_req_valid),
        .ks_req_ready (ks_req_ready),
        .ks_req_data  (ks_req_data),
        .ks_rsp_valid (ks_rsp_valid),
        .ks_rsp_data  (ks_rsp_data),
        .busy         (busy)
    );

    sbox_lane_arbiter #(.KS_PRIORITY(1'b0)) u_rr (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_req_valid (rr_st_valid),
        .st_req_ready (rr_st_ready),
        .st_req_data  (rr_st_data),
        .st_rsp_valid (rr_st_rsp_valid),
        .st_rsp_data  (rr_st_rsp_data),
        .ks_req_valid (rr_ks_valid),
        .ks_req_ready (rr_ks_ready),
        .ks_req_data  (rr_ks_data),
        .ks_rsp_valid (rr_ks_rsp_valid),
        .ks_rsp_data  (rr_ks_rsp_data),
        .busy         (rr_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Inverse in GF(2^8) followed by the FIPS-197 affine transform.
    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv;
        inv = 8'h00;
        if (v != 8'h00) begin
            inv = 8'h01;
            repeat (254) inv = gmul(inv, v);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic ks_txn(input logic [31:0] d, output logic rdy,
                          output int lat, output logic [31:0] r);
        int n;
        @(posedge clk); #1;
        ks_req_valid = 1'b1;
        ks_req_data  = d;
        #1 rdy = ks_req_ready;
        @(posedge clk); #1;
        ks_req_valid = 1'b0;
        ks_req_data  = $urandom;
        lat = -1;
        r   = '0;
        n   = 1;
        while (lat < 0 && n <= 20) begin
            @(negedge clk);
            if (ks_rsp_valid) begin
                lat = n;
                r   = ks_rsp_data;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
    endtask

    task automatic st_txn(input logic [127:0] d, output logic rdy,
                          output int lat, output logic [127:0] r);
        int n;
        @(posedge clk); #1;
        st_req_valid = 1'b1;
        st_req_data  = d;
        #1 rdy = st_req_ready;
        @(posedge clk); #1;
        st_req_valid = 1'b0;
        st_req_data  = {$urandom, $urandom, $urandom, $urandom};
        lat = -1;
        r   = '0;
        n   = 1;
        while (lat < 0 && n <= 20) begin
            @(negedge clk);
            if (st_rsp_valid) begin
                lat = n;
                r   = st_rsp_data;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({st_rsp_valid, ks_rsp_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got=%b want=000",
                     {st_rsp_valid, ks_rsp_valid, busy});
        end
        checks++;
        if (st_rsp_data !== 128'h0 || ks_rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data st=%h ks=%h want zero", st_rsp_data, ks_rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        st_req_valid = 1'b1;
        #1;
        checks++;
        if (st_req_ready !== 1'b1 || ks_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready st=%b ks=%b want 1 0", st_req_ready, ks_req_ready);
        end
        st_req_valid = 1'b0;
        #1;
        checks++;
        if (st_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready_low got=%b want=0", st_req_ready);
        end
    endtask

    task automatic test_ks;
        logic rdy;
        int lat;
        logic [31:0] r;
        ks_txn(32'h0001_53ff, rdy, lat, r);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL ks_ready got=%b want=1", rdy);
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL ks_latency got=%0d want=2", lat);
        end
        checks++;
        if (r !== 32'h637c_ed16) begin
            errors++;
            $display("FAIL ks_data got=%h want=637ced16", r);
        end
        ks_txn(32'h2f73_fa00, rdy, lat, r);
        checks++;
        if (lat != 2 || r !== 32'h158f_2d63) begin
            errors++;
            $display("FAIL ks_corner lat=%0d data=%h want 2 158f2d63", lat, r);
        end
    endtask

    task automatic test_st;
        logic rdy;
        int lat;
        logic [127:0] r;
        st_txn(ST_IN, rdy, lat, r);
        checks++;
        if (rdy !== 1'b1) begin
            errors++;
            $display("FAIL st_ready got=%b want=1", rdy);
        end
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL st_latency got=%0d want=5", lat);
        end
        checks++;
        if (r !== ST_OUT) begin
            errors++;
            $display("FAIL st_data got=%h want=%h", r, ST_OUT);
        end
        checks++;
        if (ks_rsp_data !== 32'h158f_2d63) begin
            errors++;
            $display("FAIL ks_hold got=%h want=158f2d63", ks_rsp_data);
        end
    endtask

    task automatic test_tie_priority;
        logic krdy, srdy;
        int ks_at, srdy_at, st_at;
        logic [31:0] kd;
        logic [127:0] sd;
        @(posedge clk); #1;
        ks_req_valid = 1'b1;
        ks_req_data  = 32'h0001_53ff;
        st_req_valid = 1'b1;
        st_req_data  = ST_IN;
        #1;
        krdy = ks_req_ready;
        srdy = st_req_ready;
        checks++;
        if (krdy !== 1'b1 || srdy !== 1'b0) begin
            errors++;
            $display("FAIL tie_grant ks=%b st=%b want 1 0", krdy, srdy);
        end
        @(posedge clk); #1;
        ks_req_valid = 1'b0;
        ks_at = -1;
        srdy_at = -1;
        st_at = -1;
        kd = '0;
        sd = '0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (ks_rsp_valid && ks_at < 0) begin
                ks_at = n;
                kd = ks_rsp_data;
            end
            if (st_req_ready && srdy_at < 0) srdy_at = n;
            if (st_rsp_valid && st_at < 0) begin
                st_at = n;
                sd = st_rsp_data;
            end
            @(posedge clk); #1;
            if (srdy_at == n) st_req_valid = 1'b0;
        end
        st_req_valid = 1'b0;
        checks++;
        if (ks_at != 2 || kd !== 32'h637c_ed16) begin
            errors++;
            $display("FAIL tie_ks_rsp cycle=%0d data=%h want 2 637ced16", ks_at, kd);
        end
        checks++;
        if (srdy_at != 3) begin
            errors++;
            $display("FAIL tie_st_grant cycle=%0d want=3", srdy_at);
        end
        checks++;
        if (st_at != 8 || sd !== ST_OUT) begin
            errors++;
            $display("FAIL tie_st_rsp cycle=%0d data=%h want 8 %h", st_at, sd, ST_OUT);
        end
    endtask

    task automatic test_tie_rr;
        logic [3:0] got;
        int cnt;
        logic both;
        got = '0;
        cnt = 0;
        both = 1'b0;
        @(posedge clk); #1;
        rr_ks_valid = 1'b1;
        rr_st_valid = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (rr_ks_ready && rr_st_ready) both = 1'b1;
            if (cnt < 4 && (rr_ks_ready || rr_st_ready)) begin
                got[cnt] = rr_ks_ready;
                cnt++;
            end
            @(posedge clk); #1;
        end
        rr_ks_valid = 1'b0;
        rr_st_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (cnt != 4 || got !== 4'b0101) begin
            errors++;
            $display("FAIL rr_sequence n=%0d ks_bits=%b want 4 0101", cnt, got);
        end
        checks++;
        if (both !== 1'b0) begin
            errors++;
            $display("FAIL rr_one_ready both=%b want=0", both);
        end
    endtask

    task automatic test_sweep;
        logic rdy;
        int lat;
        logic [31:0] r;
        logic [31:0] w;
        logic [31:0] exp_w;
        for (int i = 0; i < 64; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            for (int b = 0; b < 4; b++) exp_w[8*b +: 8] = sbox_ref(w[8*b +: 8]);
            ks_txn(w, rdy, lat, r);
            checks++;
            if (lat != 2 || r !== exp_w) begin
                errors++;
                $display("FAIL sweep in=%h lat=%0d got=%h want=%h", w, lat, r, exp_w);
            end
        end
    endtask

    task automatic test_reset_midop;
        logic seen;
        logic rdy;
        int lat;
        logic [127:0] r;
        @(posedge clk); #1;
        st_req_valid = 1'b1;
        st_req_data  = ST_IN;
        @(posedge clk); #1;
        st_req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_busy_before got=%b want=1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || st_rsp_valid !== 1'b0 || st_rsp_data !== 128'h0) begin
            errors++;
            $display("FAIL midop_reset busy=%b vld=%b data=%h want 0 0 0",
                     busy, st_rsp_valid, st_rsp_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (st_rsp_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midop_no_pulse got=%b want=0", seen);
        end
        st_txn(ST_IN, rdy, lat, r);
        checks++;
        if (rdy !== 1'b1 || lat != 5 || r !== ST_OUT) begin
            errors++;
            $display("FAIL midop_next rdy=%b lat=%0d data=%h want 1 5 %h",
                     rdy, lat, r, ST_OUT);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        st_req_valid = 1'b0;
        st_req_data  = '0;
        ks_req_valid = 1'b0;
        ks_req_data  = '0;
        rr_st_valid  = 1'b0;
        rr_st_data   = ST_IN;
        rr_ks_valid  = 1'b0;
        rr_ks_data   = 32'h0001_53ff;
        test_reset;
        test_ks;
        test_st;
        test_tie_priority;
        test_tie_rr;
        test_sweep;
        test_reset_midop;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
